sc_sng_array: RTL
=================

SC_SNG_ARRAY -- requirements
Module: sc_sng_array

Interface
REQ-001 Parameter K, default 3, log2 of lane count.
REQ-002 Parameter N, default 2**K, number of parallel bitstream lanes.
REQ-003 Parameter W, default 8, operand width in bits; legal range 4..16.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand vector offered.
REQ-007 in_ready  output  1  block can accept an operand vector.
REQ-008 in_data  input  N*W  lane i operand at bits [i*W +: W], unsigned unipolar value.
REQ-009 seed  input  W  LFSR start state, sampled on acceptance.
REQ-010 en  input  1  stream advance enable; 0 stalls the stream.
REQ-011 bs_valid  output  1  bs_out carries a valid stream bit this cycle.
REQ-012 bs_out  output  N  one stochastic bit per lane; feeds the neuron din or weight bus.
REQ-013 done  output  1  single-cycle pulse on the last valid stream bit.

Function
REQ-014 FSM states IDLE and RUN shall be the only states.
REQ-015 IDLE: in_ready=1, bs_valid=0, bs_out=0, done=0.
REQ-016 IDLE with in_valid=1 at a clock edge: capture in_data into per-lane operand registers, load LFSR with seed (seed==0 substituted by 1), clear cycle counter, go RUN.
REQ-017 RUN: in_ready=0; in_valid ignored.
REQ-018 Stream length LEN = 2**W-1 valid bits per accepted vector.
REQ-019 LFSR: W-bit maximal-length Fibonacci, taps from shared package, never reaches zero; advances only on cycles with RUN and en=1.
REQ-020 RUN: bs_valid = en; bs_out[i] = (rnd_i <= operand_i) from current registered LFSR state; bs_out=0 when en=0.
REQ-021 First valid bit appears the cycle after acceptance if en=1 (latency 1 cycle).
REQ-022 Over one full stream each lane emits exactly operand_i ones (0 -> all zeros, 2**W-1 -> all ones).
REQ-023 Cycle counter (W bits) increments on each valid bit; on the valid bit with count LEN-1: done=1, next state IDLE.
REQ-024 Stall: en=0 in RUN freezes LFSR, counter and operands; done never asserts on a stalled cycle.
REQ-025 No back-to-back overlap: next vector accepted no earlier than the cycle after done.

Reset
REQ-026 reset asserted: state IDLE, LFSR=1, counter=0, operands=0, in_ready=1, bs_valid=0, bs_out=0, done=0, effective immediately (asynchronous).
REQ-027 reset mid-RUN aborts the stream; no done pulse is generated for the aborted vector.

Configuration
REQ-028 Macro SC_SNG_DECORRELATE_EN defined: rnd_i = LFSR state rotated left by (i mod W) bits, decorrelating lanes.
REQ-029 Macro SC_SNG_DECORRELATE_EN undefined: rnd_i = LFSR state for all lanes (fully correlated streams).
REQ-030 Both configurations shall satisfy REQ-022 exactly (rotation is a permutation of non-zero states).

Structure
REQ-031 Shared package sc_pkg holds the LFSR tap table indexed by W (4..16), the FSM state typedef, and the seed-substitution constant.
REQ-032 Sub-module sc_lfsr (parameter W; clk, reset, load, load_val, step, state) implements the LFSR; instantiated once.

Verification
REQ-033 reset, W=8, N=8, all operands 0x80, seed 0x01, en=1 -> 255 valid bits, each lane exactly 128 ones, done once on the 255th valid bit.
REQ-034 Operands {0x00,0xFF,0x01,0x40,...}, en=1 -> lane0 0 ones, lane1 255 ones, lane2 1 one, lane3 64 ones.
REQ-035 seed=0x00 -> identical stream to seed=0x01.
REQ-036 en toggled 1,0 alternately -> 255 valid bits over 510 cycles, counts per REQ-022 unchanged, bs_out=0 on stalled cycles.
REQ-037 reset asserted at valid bit 100 -> same-cycle IDLE outputs, no done, next vector accepted and streamed from fresh seed.
REQ-038 SC_SNG_DECORRELATE_EN undefined, all operands equal -> all lanes bit-identical every cycle; defined -> lanes 0 and 1 differ in at least one cycle.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared LFSR tap table, FSM state type and seed constant for the SC stream generators.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_e;

    // A zero seed would lock the LFSR, so it is replaced by this value.
    localparam logic [15:0] SEED_SUB = 16'h0001;

    // Maximal-length feedback masks; bit W-1 is always tapped so the map is invertible.
    function automatic logic [15:0] lfsr_taps(input int w);
        logic [15:0] t;
        t = 16'h0000;
        case (w)
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0E08;
            13:      t = 16'h1C80;
            14:      t = 16'h3802;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// W-bit Fibonacci LFSR with synchronous load and step enable.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] state
);

    localparam logic [15:0]  T16  = lfsr_taps(W);
    localparam logic [W-1:0] TAPS = T16[W-1:0];

    logic fb;

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= {{(W-1){1'b0}}, 1'b1};
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {state[W-2:0], fb};
        end
    end

endmodule

// File: rtl/sc_sng_array.sv
// N-lane stochastic number generator sharing one LFSR.
// Define SC_SNG_DECORRELATE_EN to rotate the LFSR state per lane.
module sc_sng_array
    import sc_pkg::*;
#(
    parameter int K = 3,
    parameter int N = 2**K,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [W-1:0]   seed,
    input  logic           en,
    output logic           bs_valid,
    output logic [N-1:0]   bs_out,
    output logic           done
);

    localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0] SUB  = SEED_SUB[W-1:0];

    sng_state_e            state_q, state_d;
    logic [N-1:0][W-1:0]   op_q;
    logic [N-1:0][W-1:0]   rnd;
    logic [N-1:0]          hit;
    logic [W-1:0]          cnt_q;
    logic [W-1:0]          lfsr;
    logic [W-1:0]          load_val;
    logic                  accept;
    logic                  step;

    assign accept   = (state_q == IDLE) && in_valid;
    assign step     = (state_q == RUN) && en;
    assign load_val = (seed == '0) ? SUB : seed;

    sc_lfsr #(.W(W)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (load_val),
        .step     (step),
        .state    (lfsr)
    );

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int R = i % W;
`ifdef SC_SNG_DECORRELATE_EN
        if (R == 0) begin : g_norot
            assign rnd[i] = lfsr;
        end else begin : g_rot
            assign rnd[i] = {lfsr[W-1-R:0], lfsr[W-1:W-R]};
        end
`else
        assign rnd[i] = lfsr;
`endif
        assign hit[i] = (rnd[i] <= op_q[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= in_data;
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        bs_valid = 1'b0;
        bs_out   = '0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                bs_valid = en;
                if (en) begin
                    bs_out = hit;
                    if (cnt_q == LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

endmodule
